alu_md_seq: RTL and testbench
=============================

// Module: alu_md_seq
// PURPOSE
//   Parametrised sequential ALU for the multi-cycle datapath. Adds iterative MULT/MULTU/DIV/DIVU
//   with architectural HI/LO registers, signed-overflow and zero flags, and SRA.
//   Uses a valid/ready handshake on both sides and registers every result.
//   Sits between the register-file read stage and the writeback mux.
//   The controller stalls on in_ready/out_valid.
// PARAMETERS
//   WIDTH   32   datapath width; even, >=8
//   SHW     5    shift-amount width; must equal $clog2(WIDTH)
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous, active-high reset
//   in_valid   in   1       operands/op valid
//   in_ready   out  1       unit can accept; transfer when in_valid & in_ready
//   op         in   4       0 NOP(C=A) 1 ADD 2 SUB 3 AND 4 OR 5 NOR 6 SLT 7 SLTU 8 SLL 9 SRL
//                           10 SRA 11 LUI(B<<WIDTH/2) 12 MULT 13 MULTU 14 DIV 15 DIVU
//   a          in   WIDTH   operand A
//   b          in   WIDTH   operand B
//   shamt      in   SHW     shift amount for ops 8-10 (controller muxes shamt or A[SHW-1:0])
//   out_valid  out  1       result valid; held until out_ready
//   out_ready  in   1       consumer accepts result
//   result     out  WIDTH   registered result (MD ops: new LO)
//   zero       out  1       registered (result == 0)
//   ovf        out  1       registered signed overflow; ADD/SUB only, else 0
//   hi         out  WIDTH   HI register
//   lo         out  WIDTH   LO register
// BEHAVIOUR
//   Reset: state=IDLE; out_valid, result, zero, ovf, hi, lo = 0.
//     in_ready=0 while rst=1. Reset mid-operation aborts it: no result, HI/LO cleared.
//   in_ready = (state==IDLE) & (!out_valid | out_ready) & !rst.
//     Back-to-back single-cycle ops give 1 result/cycle.
//   FSM states: IDLE, ITER, FIX.
//     IDLE + accept of ops 0-11: result/zero/ovf written at that edge; out_valid=1 next cycle.
//       Latency 1; HI/LO unchanged.
//     IDLE + accept of ops 12-15: latch operands; for signed ops latch |a| and |b| plus result signs;
//       cnt=0; go to ITER.
//     ITER: one radix-2 step per cycle. MUL: shift-add. DIV: restoring.
//       cnt increments; after WIDTH steps (cnt==WIDTH-1) go to FIX.
//     FIX: apply sign correction; write hi, lo, result=lo, zero, ovf=0; set out_valid; go to IDLE.
//       Fixed latency: out_valid rises WIDTH+1 edges after the accept edge, for all MD ops.
//   out_valid/result stay stable while out_valid & !out_ready; clear on handshake unless a new op
//     completes on the same edge.
//   Arithmetic rules:
//     ADD/SUB wrap mod 2^WIDTH.
//     ovf = signs of operands (B inverted for SUB) equal and result sign differs.
//     SLT is signed, SLTU unsigned; result is 1 or 0.
//     SRA replicates B[WIDTH-1]; shifts operate on B; shamt is SHW bits (no masking needed).
//     MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product.
//     DIV/DIVU: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
//     Divide by zero (b==0): lo = all ones, hi = a; full latency; no exception.
//     DIV of MIN by -1: lo = MIN, hi = 0.
//   Ops 0-11 accepted while an MD op is idle never modify HI/LO.
//   Undefined behaviour: none; all 16 codes are defined.
// TESTING (WIDTH=32)
//   Reset, then ADD a=7FFFFFFF b=1 -> next cycle out_valid=1, result=80000000, ovf=1, zero=0.
//   SUB a=5 b=5 with out_ready=1, then SRA a=x b=F0000000 shamt=4 on consecutive cycles
//     -> results 0 (zero=1), then FF000000; in_ready stays high throughout.
//   MULT a=FFFFFFFE(-2) b=00000003 -> out_valid exactly 33 cycles after accept;
//     hi=FFFFFFFF, lo=FFFFFFFA; in_ready=0 throughout.
//   DIV a=-7 b=2 -> lo=FFFFFFFD(-3), hi=FFFFFFFF(-1).
//   DIVU a=7 b=0 -> lo=FFFFFFFF, hi=7.
//   DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=0.
//   Hold out_ready=0 for 5 cycles after an MD completes -> result/hi/lo stable, in_ready=0.
//   Assert rst at ITER cycle 10 -> out_valid never rises, hi=lo=0; next op runs normally.

Source files
------------

// File: rtl/alu_md_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus iterative MULT/MULTU/DIV/DIVU into HI/LO.
// Latency: 1 edge for ops 0-11, WIDTH+1 edges for multiply/divide ops.
// Backpressure: result held while out_valid & !out_ready; in_ready only when IDLE and output free.
module alu_md_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_LUI  = 4'd11;
  localparam logic [3:0] OP_MULT = 4'd12;
  localparam logic [3:0] OP_DIV  = 4'd14;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t             state_q;
  logic [SHW-1:0]     cnt_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               ovf_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  // Iteration working set: rem_q is the upper half (partial product / remainder),
  // quo_q the lower half (multiplier bits / dividend-then-quotient), opb_q the |B| operand.
  logic               md_div_q;
  logic               prod_neg_q;   // sign of product / quotient
  logic               rem_neg_q;    // sign of remainder (follows dividend)
  logic               div0_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   opb_q;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               md_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_trial;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready) && !rst;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  assign sum  = a + b;
  assign diff = a - b;

  // Signed MD ops run on magnitudes; signs are reapplied in FIX.
  assign md_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = md_signed && a[WIDTH-1];
  assign b_neg     = md_signed && b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Single-cycle result and overflow for ops 0-11.
  always_comb begin
    alu_res = a;
    alu_ovf = 1'b0;
    case (op)
      OP_NOP:  alu_res = a;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  alu_res = b << shamt;
      OP_SRL:  alu_res = b >> shamt;
      OP_SRA:  alu_res = $signed(b) >>> shamt;
      OP_LUI:  alu_res = b << (WIDTH / 2);
      default: alu_res = a;
    endcase
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {rem_q, quo_q[WIDTH-1]};
    // The partial remainder stays below the divisor, so the low WIDTH bits of the difference are exact.
    div_trial = div_shift[WIDTH-1:0] - opb_q;
    if (md_div_q) begin
      if (div_shift >= {1'b0, opb_q}) begin
        rem_d = div_trial;
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = div_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      rem_d = mul_sum[WIDTH:1];
      quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
    end
  end

  // Sign correction and divide-by-zero override for the final HI/LO values.
  always_comb begin
    prod_raw = {rem_q, quo_q};
    prod_fix = prod_neg_q ? -prod_raw : prod_raw;
    if (md_div_q) begin
      lo_d = div0_q ? '1 : (prod_neg_q ? -quo_q : quo_q);
      hi_d = rem_neg_q ? -rem_q : rem_q;
    end else begin
      hi_d = prod_fix[2*WIDTH-1:WIDTH];
      lo_d = prod_fix[WIDTH-1:0];
    end
  end

  // Control FSM with all result/flag/HI/LO registers; reset aborts any MD op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      md_div_q    <= 1'b0;
      prod_neg_q  <= 1'b0;
      rem_neg_q   <= 1'b0;
      div0_q      <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      opb_q       <= '0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (op[3:2] == 2'b11) begin
              md_div_q   <= op[1];
              prod_neg_q <= a_neg ^ b_neg;
              rem_neg_q  <= a_neg;
              div0_q     <= (b == '0);
              rem_q      <= '0;
              quo_q      <= a_mag;
              opb_q      <= b_mag;
              cnt_q      <= '0;
              state_q    <= ITER;
            end else begin
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              ovf_q       <= alu_ovf;
              out_valid_q <= 1'b1;
            end
          end
        end
        ITER: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + SHW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q        <= hi_d;
          lo_q        <= lo_d;
          result_q    <= lo_d;
          zero_q      <= (lo_d == '0);
          ovf_q       <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md_seq.sv
// Bench for alu_md_seq (WIDTH=32): transaction-level model plus directed vectors.
`timescale 1ns/1ps
module tb_alu_md_seq;
  localparam int W = 32;
  localparam longint SMAX = 64'sh7FFFFFFF;
  localparam longint SMIN = -64'sh80000000;

  localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, AND_ = 4'd3, OR_ = 4'd4,
                         NOR_ = 4'd5, SLT = 4'd6, SLTU = 4'd7, SLL = 4'd8, SRL = 4'd9,
                         SRA = 4'd10, LUI = 4'd11, MULT = 4'd12, MULTU = 4'd13,
                         DIV = 4'd14, DIVU = 4'd15;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready;
  logic         in_ready, out_valid, zero, ovf;
  logic [3:0]   op_r;
  logic [W-1:0] a_r, b_r;
  logic [4:0]   sh_r;
  logic [W-1:0] result, hi, lo;

  int checks = 0;
  int errors = 0;

  // Model state
  logic         m_valid = 1'b0, m_busy = 1'b0, m_zero = 1'b0, m_ovf = 1'b0;
  int           m_cnt = 0;
  logic [W-1:0] m_res = '0, m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;

  always #5 clk = ~clk;

  alu_md_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op_r),
    .a(a_r), .b(b_r), .shamt(sh_r), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf), .hi(hi), .lo(lo)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void alu_model(input logic [3:0] o, input logic [W-1:0] x, y,
                                    input logic [4:0] s, output logic [W-1:0] r, output logic v);
    longint sx, sy, t;
    sx = $signed(x);
    sy = $signed(y);
    v  = 1'b0;
    r  = x;
    case (o)
      ADD:  begin t = sx + sy; r = t[31:0]; v = (t > SMAX) || (t < SMIN); end
      SUB:  begin t = sx - sy; r = t[31:0]; v = (t > SMAX) || (t < SMIN); end
      AND_: r = x & y;
      OR_:  r = x | y;
      NOR_: r = ~(x | y);
      SLT:  r = (sx < sy) ? 32'd1 : 32'd0;
      SLTU: r = (x < y) ? 32'd1 : 32'd0;
      SLL:  r = y << s;
      SRL:  r = y >> s;
      SRA:  r = $signed(y) >>> s;
      LUI:  r = y << 16;
      default: r = x;
    endcase
  endfunction

  function automatic void md_model(input logic [3:0] o, input logic [W-1:0] x, y,
                                   output logic [W-1:0] h, output logic [W-1:0] l);
    longint sx, sy, q, rm;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      MULT:  p = sx * sy;
      MULTU: p = {32'b0, x} * {32'b0, y};
      DIV: begin
        if (y == 0) p = {x, 32'hFFFFFFFF};
        else begin q = sx / sy; rm = sx % sy; p = {rm[31:0], q[31:0]}; end
      end
      default: begin
        if (y == 0) p = {x, 32'hFFFFFFFF};
        else p = {x % y, x / y};
      end
    endcase
    h = p[63:32];
    l = p[31:0];
  endfunction

  // Transaction-level model, advanced once per rising edge from the bench's own inputs.
  always @(posedge clk) begin : model
    logic acc, done, v;
    logic [W-1:0] r;
    acc = in_valid && !m_busy && (!m_valid || out_ready) && !rst;
    if (rst) begin
      m_valid = 0; m_busy = 0; m_cnt = 0; m_res = '0; m_zero = 0; m_ovf = 0;
      m_hi = '0; m_lo = '0;
    end else begin
      done = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) done = 1'b1;
      end
      if (m_valid && out_ready) m_valid = 1'b0;
      if (acc) begin
        if (op_r >= 4'd12) begin
          md_model(op_r, a_r, b_r, m_phi, m_plo);
          m_busy = 1'b1;
          m_cnt  = W + 1;
        end else begin
          alu_model(op_r, a_r, b_r, sh_r, r, v);
          m_res = r; m_zero = (r == 0); m_ovf = v; m_valid = 1'b1;
        end
      end
      if (done) begin
        m_busy = 1'b0; m_valid = 1'b1;
        m_hi = m_phi; m_lo = m_plo; m_res = m_plo; m_zero = (m_plo == 0); m_ovf = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model on the falling edge.
  initial begin : compare
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      chk("cmp_out_valid", 32'(out_valid), 32'(m_valid));
      chk("cmp_in_ready", 32'(in_ready), 32'(!m_busy && (!m_valid || out_ready) && !rst));
      if (m_valid) begin
        chk("cmp_result", result, m_res);
        chk("cmp_zero", 32'(zero), 32'(m_zero));
        chk("cmp_ovf", 32'(ovf), 32'(m_ovf));
      end
      chk("cmp_hi", hi, m_hi);
      chk("cmp_lo", lo, m_lo);
    end
  end

  task automatic drive(input logic [3:0] o, input logic [W-1:0] x, y, input logic [4:0] s);
    op_r = o; a_r = x; b_r = y; sh_r = s; in_valid = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, y, input logic [4:0] s);
    int n;
    drive(o, x, y, s);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: in_ready never rose for op %0d", o);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n, output logic rdy_seen);
    n = 0;
    rdy_seen = 1'b0;
    while (!out_valid && n < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL wait_valid_timeout: out_valid low after %0d cycles", n);
    end
  endtask

  task automatic alu_vec(input logic [3:0] o, input logic [W-1:0] x, y, input logic [4:0] s,
                         input logic [W-1:0] exp_r, input logic exp_v);
    issue(o, x, y, s);
    chk($sformatf("vec_op%0d_result", o), result, exp_r);
    chk($sformatf("vec_op%0d_ovf", o), 32'(ovf), 32'(exp_v));
  endtask

  initial begin : main
    int n;
    logic rdy_seen, vbad;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op_r = '0; a_r = '0; b_r = '0; sh_r = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ADD overflow
    issue(ADD, 32'h7FFFFFFF, 32'h1, 5'd0);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_result", result, 32'h80000000);
    chk("add_ovf", 32'(ovf), 32'd1);
    chk("add_zero", 32'(zero), 32'd0);
    chk("model_add_ovf", 32'(m_ovf), 32'd1);

    // SUB then SRA back to back
    drive(SUB, 32'h5, 32'h5, 5'd0);
    @(negedge clk);
    chk("b2b_rdy0", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    drive(SRA, 32'h12345678, 32'hF0000000, 5'd4);
    @(negedge clk);
    chk("b2b_sub_result", result, 32'h0);
    chk("b2b_sub_zero", 32'(zero), 32'd1);
    chk("b2b_rdy1", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_sra_valid", 32'(out_valid), 32'd1);
    chk("b2b_sra_result", result, 32'hFF000000);

    // Single-cycle ops with hand-computed results
    alu_vec(NOP,  32'h12345678, 32'h0,        5'd0,  32'h12345678, 1'b0);
    alu_vec(AND_, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h00F000F0, 1'b0);
    alu_vec(OR_,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'hFFF0FFF0, 1'b0);
    alu_vec(NOR_, 32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 1'b0);
    alu_vec(SLT,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        1'b0);
    alu_vec(SLTU, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b0);
    alu_vec(SLL,  32'h0,        32'h1,        5'd31, 32'h80000000, 1'b0);
    alu_vec(SRL,  32'h0,        32'h80000000, 5'd31, 32'h1,        1'b0);
    alu_vec(SRA,  32'h0,        32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0);
    alu_vec(LUI,  32'h0,        32'h0000ABCD, 5'd0,  32'hABCD0000, 1'b0);
    alu_vec(SUB,  32'h80000000, 32'h1,        5'd0,  32'h7FFFFFFF, 1'b1);
    alu_vec(ADD,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b0);

    // MULT -2 * 3 with latency check
    issue(MULT, 32'hFFFFFFFE, 32'h3, 5'd0);
    wait_valid(n, rdy_seen);
    chk("mult_latency", 32'(n), 32'd33);
    chk("mult_rdy_low", 32'(rdy_seen), 32'd0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    chk("mult_result", result, 32'hFFFFFFFA);
    chk("model_mult_hi", m_hi, 32'hFFFFFFFF);

    issue(DIV, 32'hFFFFFFF9, 32'h2, 5'd0);
    wait_valid(n, rdy_seen);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("model_div_lo", m_lo, 32'hFFFFFFFD);

    issue(DIVU, 32'h7, 32'h0, 5'd0);
    wait_valid(n, rdy_seen);
    chk("divu0_latency", 32'(n), 32'd33);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 32'h7);

    issue(DIV, 32'h80000000, 32'hFFFFFFFF, 5'd0);
    wait_valid(n, rdy_seen);
    chk("divmin_lo", lo, 32'h80000000);
    chk("divmin_hi", hi, 32'h0);

    // Output backpressure after an MD completion
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(MULTU, 32'h00010000, 32'h00010000, 5'd0);
    wait_valid(n, rdy_seen);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", result, 32'h0);
      chk("hold_hi", hi, 32'h1);
      chk("hold_lo", lo, 32'h0);
      chk("hold_rdy", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // A single-cycle op leaves HI/LO alone
    issue(ADD, 32'h2, 32'h3, 5'd0);
    chk("add_after_md_result", result, 32'h5);
    chk("add_after_md_hi", hi, 32'h1);

    // Reset during ITER aborts the divide
    issue(DIVU, 32'd100, 32'd3, 5'd0);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vbad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) vbad = 1'b1;
    end
    chk("abort_no_valid", 32'(vbad), 32'd0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    @(posedge clk); #1;
    issue(MULT, 32'h3, 32'h4, 5'd0);
    wait_valid(n, rdy_seen);
    chk("post_abort_latency", 32'(n), 32'd33);
    chk("post_abort_lo", lo, 32'hC);
    chk("post_abort_hi", hi, 32'h0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
